// File: rtl/dzcpu_useq.sv
// dzcpu_useq: microcode sequencer. Fetches an opcode, walks its micro-op ROM flow one entry per cycle,
// and emits execute strobes plus PC-increment, flag-update, retire and illegal pulses to the datapath.
module dzcpu_useq #(
  parameter logic [2:0] FL_OP         = 3'd0,
  parameter logic [2:0] FL_INC        = 3'd1,
  parameter logic [2:0] FL_EOF        = 3'd2,
  parameter logic [2:0] FL_INC_EOF    = 3'd3,
  parameter logic [2:0] FL_EOF_FU     = 3'd4,
  parameter logic [2:0] FL_INC_EOF_FU = 3'd5,
  parameter logic [2:0] FL_INC_EOF_Z  = 3'd6,
  parameter logic [4:0] UOP_JCB       = 5'd31,
  parameter int         WDOG_MAX      = 64
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMemData,
  input  logic        iMemReady,
  input  logic        iStall,
  input  logic        iZeroFlag,
  output logic [7:0]  oMop,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  output logic [7:0]  oUopAddr,
  input  logic [12:0] iUop,
  output logic        oUopValid,
  output logic [9:0]  oUop,
  output logic        oPcInc,
  output logic        oFlagUpdate,
  output logic        oRetire,
  output logic        oIllegal
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXEC    = 2'd2,
    CBFETCH = 2'd3
  } state_t;

  localparam logic [6:0] LP_WDOG_LAST = 7'(WDOG_MAX - 1);

  state_t     rState, w_state_nxt;
  logic [7:0] rUPC, w_upc_nxt;
  logic [7:0] rMop, w_mop_nxt;
  logic       rCb, w_cb_nxt;
  logic [6:0] rWdog, w_wdog_nxt;

  logic [2:0] w_flow;
  logic       w_jcb;
  logic       w_wdog_hit;
  logic       w_eof;

  assign w_flow     = iUop[12:10];
  assign w_jcb      = (iUop[9:5] == UOP_JCB);
  assign w_wdog_hit = (rWdog == LP_WDOG_LAST);
  assign oUopAddr   = rUPC;
  assign oMop       = rMop;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      rState <= FETCH;
      rUPC   <= 8'h00;
      rMop   <= 8'h00;
      rCb    <= 1'b0;
      rWdog  <= 7'd0;
    end else begin
      rState <= w_state_nxt;
      rUPC   <= w_upc_nxt;
      rMop   <= w_mop_nxt;
      rCb    <= w_cb_nxt;
      rWdog  <= w_wdog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = rState;
    w_upc_nxt   = rUPC;
    w_mop_nxt   = rMop;
    w_cb_nxt    = rCb;
    w_wdog_nxt  = rWdog;
    w_eof       = 1'b0;
    oUopValid   = 1'b0;
    oUop        = 10'd0;
    oPcInc      = 1'b0;
    oFlagUpdate = 1'b0;
    oRetire     = 1'b0;
    oIllegal    = 1'b0;

    // A stall freezes every register and silences all strobes.
    if (!iStall) begin
      case (rState)
        FETCH, CBFETCH: begin
          if (iMemReady) begin
            w_mop_nxt   = iMemData;
            w_cb_nxt    = (rState == CBFETCH);
            w_state_nxt = DECODE;
          end
        end
        DECODE: begin
          w_upc_nxt   = rCb ? iCbFlowIdx : iFlowIdx;
          w_wdog_nxt  = 7'd0;
          w_state_nxt = EXEC;
        end
        EXEC: begin
          oUopValid  = 1'b1;
          oUop       = iUop[9:0];
          w_wdog_nxt = rWdog + 7'd1;
          case (w_flow)
            FL_OP:         ;
            FL_INC:        oPcInc = 1'b1;
            FL_EOF:        w_eof = 1'b1;
            FL_INC_EOF:    begin oPcInc = 1'b1; w_eof = 1'b1; end
            FL_EOF_FU:     begin oFlagUpdate = 1'b1; w_eof = 1'b1; end
            FL_INC_EOF_FU: begin oPcInc = 1'b1; oFlagUpdate = 1'b1; w_eof = 1'b1; end
            FL_INC_EOF_Z:  begin oPcInc = 1'b1; w_eof = iZeroFlag; end
            default:       begin oIllegal = 1'b1; w_eof = 1'b1; end
          endcase
          // JCB hands off to the CB table without retiring; it also counts as leaving the flow.
          if (w_jcb) begin
            w_state_nxt = CBFETCH;
          end else if (w_eof) begin
            oRetire     = 1'b1;
            w_state_nxt = FETCH;
          end else if (w_wdog_hit) begin
            oIllegal    = 1'b1;
            oRetire     = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_upc_nxt = rUPC + 8'd1;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: ROM/LUT contents live here; each instruction's expected uop trace is derived
// by walking the flow rules over the ROM, then compared against what the sequencer actually issued.
module tb_dzcpu_useq;

  localparam logic [2:0] F_OP = 3'd0, F_INC = 3'd1, F_EOF = 3'd2, F_INC_EOF = 3'd3;
  localparam logic [2:0] F_EOF_FU = 3'd4, F_INC_EOF_FU = 3'd5, F_INC_EOF_Z = 3'd6, F_RSV = 3'd7;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMemData = 8'h00;
  logic        iMemReady = 1'b0;
  logic        iStall = 1'b0;
  logic        iZeroFlag = 1'b0;
  logic [7:0]  oMop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic        oUopValid;
  logic [9:0]  oUop;
  logic        oPcInc;
  logic        oFlagUpdate;
  logic        oRetire;
  logic        oIllegal;

  logic [12:0] rom [256];
  logic [7:0]  flowlut [256];
  logic [7:0]  cblut [256];
  logic [12:0] rom_save [8];
  logic [17:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  assign iUop       = rom[oUopAddr];
  assign iFlowIdx   = flowlut[oMop];
  assign iCbFlowIdx = cblut[oMop];

  always #5 iClock = ~iClock;

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .iMemReady(iMemReady),
    .iStall(iStall), .iZeroFlag(iZeroFlag), .oMop(oMop), .iFlowIdx(iFlowIdx),
    .iCbFlowIdx(iCbFlowIdx), .oUopAddr(oUopAddr), .iUop(iUop), .oUopValid(oUopValid),
    .oUop(oUop), .oPcInc(oPcInc), .oFlagUpdate(oFlagUpdate), .oRetire(oRetire),
    .oIllegal(oIllegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Walk the flow from the opcode's table entry, following the flow-code rules directly.
  function automatic void model(input logic [7:0] op, input logic [7:0] op2, input logic z,
                                output int n, output int pcinc, output int fu, output int ill,
                                output int cycles, output bit cbused);
    logic [7:0]  a;
    logic [12:0] w;
    int          seg;
    exp_q.delete();
    n = 0; pcinc = 0; fu = 0; ill = 0; cycles = 2; cbused = 0; seg = 0;
    a = flowlut[op];
    for (int g = 0; g < 1000; g++) begin
      w = rom[a];
      exp_q.push_back({a, w[9:0]});
      n++; seg++; cycles++;
      if (w[12:10] inside {F_INC, F_INC_EOF, F_INC_EOF_FU, F_INC_EOF_Z}) pcinc++;
      if (w[12:10] inside {F_EOF_FU, F_INC_EOF_FU}) fu++;
      if (w[12:10] == F_RSV) ill++;
      if (w[9:5] == 5'd31) begin
        a = cblut[op2]; seg = 0; cycles += 2; cbused = 1;
        continue;
      end
      if (w[12:10] inside {F_EOF, F_INC_EOF, F_EOF_FU, F_INC_EOF_FU, F_RSV}) break;
      if (w[12:10] == F_INC_EOF_Z && z) break;
      if (seg == 64) begin ill++; break; end
      a = a + 8'd1;
    end
  endfunction

  task automatic run_instr(input string tag, input logic [7:0] op, input logic [7:0] op2,
                           input logic z, input int stall_pct, input int idle);
    int n, pcinc, fu, ill, cyc;
    bit cbused;
    int a_pc = 0, a_fu = 0, a_ill = 0, a_cyc = 0, first = -1;
    bit consumed = 0, done = 0;
    logic [17:0] got_q [$];
    model(op, op2, z, n, pcinc, fu, ill, cyc, cbused);
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge iClock); #1;
      iStall    = ($urandom_range(99) < stall_pct);
      iZeroFlag = z;
      iMemReady = (c >= idle);
      iMemData  = consumed ? op2 : op;
      @(negedge iClock);
      if (iStall) begin
        chk({tag, ":stall_quiet"}, {27'd0, oUopValid, oPcInc, oFlagUpdate, oRetire, oIllegal}, 0);
      end else begin
        if (iMemReady) consumed = 1;
        if (consumed) a_cyc++;
        if (oUopValid) begin
          if (first < 0) first = a_cyc;
          got_q.push_back({oUopAddr, oUop});
        end
        a_pc  += int'(oPcInc);
        a_fu  += int'(oFlagUpdate);
        a_ill += int'(oIllegal);
        if (oRetire) done = 1;
      end
    end
    iStall = 1'b0;
    chk({tag, ":retired"}, 32'(done), 1);
    chk({tag, ":uop_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk({tag, ":addr_uop"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, ":pc_inc"}, a_pc, pcinc);
    chk({tag, ":flag_upd"}, a_fu, fu);
    chk({tag, ":illegal"}, a_ill, ill);
    chk({tag, ":first_uop_cycle"}, first, 3);
    chk({tag, ":cycles"}, a_cyc, cyc);
    chk({tag, ":mop"}, 32'(oMop), 32'(cbused ? op2 : op));
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int r;
    logic [2:0] f;
    for (int a = 0; a < 256; a++) rom[a] = {F_EOF, 5'd1, 5'd0};
    for (int a = 64; a < 200; a++) begin
      r = $urandom_range(9);
      f = (r < 5) ? 3'($urandom_range(1)) : 3'($urandom_range(7, 2));
      rom[a] = {f, 5'($urandom_range(30)), 5'($urandom_range(31))};
    end
    for (int a = 200; a < 256; a++) rom[a] = {F_OP, 5'($urandom_range(30)), 5'(a)};
    rom[0]  = {F_INC_EOF, 5'd4, 5'd9};
    rom[1]  = {F_INC, 5'd2, 5'd1};
    rom[2]  = {F_INC, 5'd3, 5'd2};
    rom[3]  = {F_OP, 5'd5, 5'd3};
    rom[4]  = {F_INC_EOF, 5'd6, 5'd4};
    rom[16] = {F_EOF_FU, 5'd7, 5'd16};
    rom[17] = {F_OP, 5'd8, 5'd17};
    rom[18] = {F_INC, 5'd9, 5'd18};
    rom[19] = {F_INC_EOF_Z, 5'd10, 5'd19};
    rom[20] = {F_OP, 5'd11, 5'd20};
    rom[21] = {F_OP, 5'd12, 5'd21};
    rom[22] = {F_INC_EOF, 5'd13, 5'd22};
    rom[30] = {F_INC, 5'd31, 5'd2};
    rom[40] = {F_RSV, 5'd3, 5'd0};
    for (int i = 0; i < 256; i++) begin
      flowlut[i] = 8'($urandom_range(199, 64));
      cblut[i]   = 8'($urandom_range(199, 64));
    end
    flowlut[8'h00] = 8'd0;
    flowlut[8'h31] = 8'd1;
    flowlut[8'h20] = 8'd17;
    flowlut[8'hCB] = 8'd30;
    flowlut[8'h40] = 8'd200;
    flowlut[8'h41] = 8'd40;
    cblut[8'h7C]   = 8'd16;

    #2;
    chk("rst_valid", 32'(oUopValid), 0);
    chk("rst_pulses", {28'd0, oPcInc, oFlagUpdate, oRetire, oIllegal}, 0);
    chk("rst_upc", 32'(oUopAddr), 0);
    chk("rst_mop", 32'(oMop), 0);
    chk("rst_uop", 32'(oUop), 0);
    @(posedge iClock); #1;
    iReset = 1'b0;

    run_instr("op00", 8'h00, 8'h00, 1'b0, 0, 0);
    run_instr("op31", 8'h31, 8'h00, 1'b0, 0, 0);
    run_instr("condZ1", 8'h20, 8'h00, 1'b1, 0, 0);
    run_instr("condZ0", 8'h20, 8'h00, 1'b0, 0, 0);
    run_instr("cb7C", 8'hCB, 8'h7C, 1'b0, 0, 0);
    run_instr("reserved", 8'h41, 8'h00, 1'b0, 0, 1);

    for (int a = 0; a < 8; a++) begin
      rom_save[a] = rom[a];
      rom[a] = {F_OP, 5'd0, 5'(a)};
    end
    run_instr("wdog", 8'h40, 8'h00, 1'b0, 0, 0);
    run_instr("wdog_stall", 8'h40, 8'h00, 1'b1, 30, 2);
    run_instr("stall31", 8'h31, 8'h00, 1'b0, 50, 0);

    // Reset in the middle of the watchdog flow: outputs drop at once, nothing retires.
    @(posedge iClock); #1;
    iMemReady = 1'b1; iMemData = 8'h40; iStall = 1'b0;
    repeat (5) @(posedge iClock);
    #3;
    chk("mid_upc", 32'(oUopAddr), 203);
    chk("mid_valid", 32'(oUopValid), 1);
    iReset = 1'b1;
    #1;
    chk("arst_valid", 32'(oUopValid), 0);
    chk("arst_pulses", {28'd0, oPcInc, oFlagUpdate, oRetire, oIllegal}, 0);
    chk("arst_upc", 32'(oUopAddr), 0);
    chk("arst_mop", 32'(oMop), 0);
    chk("arst_uop", 32'(oUop), 0);
    iMemReady = 1'b0;
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock);
    chk("post_rst_upc", 32'(oUopAddr), 0);
    chk("post_rst_valid", 32'(oUopValid), 0);
    for (int a = 0; a < 8; a++) rom[a] = rom_save[a];
    run_instr("after_rst", 8'h31, 8'h00, 1'b0, 0, 0);

    for (int k = 0; k < 40; k++)
      run_instr("rand", 8'($urandom_range(255)), 8'($urandom_range(255)),
                1'($urandom_range(1)), 25, $urandom_range(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
